// File: rtl/obi_pkg.sv
// Shared OBI bus widths and payload types used by OBI primaries and secondaries.
package obi_pkg;

  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = 4;

  typedef struct packed {
    logic [OBI_AW-1:0]  addr;
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  typedef struct packed {
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
  } obi_rsp_t;

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-latency response delay line carrying {valid, data}; synchronous
// active-low clear drops everything in flight.
module obi_resp_pipe
  import obi_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic     clk_i,
  input  logic     clr_ni,
  input  obi_rsp_t rsp_d,
  output obi_rsp_t rsp_q
);

  obi_rsp_t [LATENCY-1:0] stage_q;

  if (LATENCY == 1) begin : g_single
    always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
        stage_q <= '0;
      end else begin
        stage_q <= rsp_d;
      end
    end
  end else begin : g_shift
    always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
        stage_q <= '0;
      end else begin
        stage_q <= {stage_q[LATENCY-2:0], rsp_d};
      end
    end
  end

  assign rsp_q = stage_q[LATENCY-1];

endmodule

// File: rtl/obi_sram_secondary.sv
// OBI secondary in front of a byte-writable word SRAM, with configurable
// grant wait-states, fixed response latency and an outstanding-transaction cap.
module obi_sram_secondary
  import obi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS     = 256,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RVALID_LATENCY  = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [OBI_AW-1:0]  addr_i,
  input  logic               we_i,
  input  logic [OBI_BEW-1:0] be_i,
  input  logic [OBI_DW-1:0]  wdata_i,
  output logic               rvalid_o,
  output logic [OBI_DW-1:0]  rdata_o
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned WCW = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);

  obi_req_t          req;
  obi_rsp_t          rsp_d;
  obi_rsp_t          rsp_q;
  logic [AW-1:0]     widx;
  logic [WCW-1:0]    wcnt_q;
  logic [OCW-1:0]    ocnt_q;
  logic              wait_done;
  logic              slot_free;
  logic              accept;
  logic              unused_addr_bits;
  logic [OBI_DW-1:0] mem_q [DEPTH_WORDS];

  assign req = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};

  // Out-of-range addresses wrap; byte offset within the word is ignored.
  assign widx             = req.addr[AW+1:2];
  assign unused_addr_bits = ^{req.addr[OBI_AW-1:AW+2], req.addr[1:0]};

  // A slot freed by a response this cycle may be reused by the same-cycle grant.
  assign wait_done = (wcnt_q == WCW'(GNT_WAIT));
  assign slot_free = (ocnt_q < OCW'(MAX_OUTSTANDING)) || rsp_q.rvalid;
  assign gnt_o     = rst_ni && req_i && wait_done && slot_free;
  assign accept    = req_i && gnt_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wcnt_q <= '0;
    end else if (!req_i || accept) begin
      wcnt_q <= '0;
    end else if (!wait_done) begin
      wcnt_q <= wcnt_q + WCW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ocnt_q <= '0;
    end else if (accept && !rsp_q.rvalid) begin
      ocnt_q <= ocnt_q + OCW'(1);
    end else if (!accept && rsp_q.rvalid) begin
      ocnt_q <= ocnt_q - OCW'(1);
    end
  end

  // SRAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && req.we) begin
      for (int unsigned b = 0; b < OBI_BEW; b++) begin
        if (req.be[b]) begin
          mem_q[widx][8*b +: 8] <= req.wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rsp_d = '0;
    if (accept) begin
      rsp_d.rvalid = 1'b1;
      if (!req.we) begin
        rsp_d.rdata = mem_q[widx];
      end
    end
  end

  obi_resp_pipe #(
    .LATENCY (RVALID_LATENCY)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .clr_ni (rst_ni),
    .rsp_d  (rsp_d),
    .rsp_q  (rsp_q)
  );

  assign rvalid_o = rsp_q.rvalid;
  assign rdata_o  = rsp_q.rdata;

endmodule

// File: tb/tb_obi_sram_secondary.sv
// Scoreboard bench for obi_sram_secondary across three parameter sets:
// default, wait-stated, and long-latency with outstanding cap.
module tb_obi_sram_secondary;
  import obi_pkg::*;

  localparam int N = 3;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req    [N];
  logic        gnt    [N];
  logic [31:0] addr   [N];
  logic        we     [N];
  logic [3:0]  be     [N];
  logic [31:0] wdata  [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];

  exp_t exp_q [N][$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   max_ocnt = 0;
  bit   track_ocnt = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  obi_sram_secondary #(.DEPTH_WORDS(256), .GNT_WAIT(0), .RVALID_LATENCY(1), .MAX_OUTSTANDING(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]));

  obi_sram_secondary #(.DEPTH_WORDS(256), .GNT_WAIT(2), .RVALID_LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]));

  obi_sram_secondary #(.DEPTH_WORDS(256), .GNT_WAIT(0), .RVALID_LATENCY(3), .MAX_OUTSTANDING(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
    .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected entry, in data and cycle.
  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (rvalid[d] === 1'b1) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid dut%0d: got rdata %h expected no response (cycle %0d)", d, rdata[d], cyc);
        end else begin
          e = exp_q[d].pop_front();
          check($sformatf("rdata_dut%0d", d), rdata[d], e.data);
          check($sformatf("rvalid_cycle_dut%0d", d), 32'(cyc), 32'(e.due));
        end
      end
    end
    if (track_ocnt && int'(dut_c.ocnt_q) > max_ocnt) max_ocnt = int'(dut_c.ocnt_q);
  end

  // Present a transaction, hold until granted; returns cycles from request to accept edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic [31:0] want, output int off);
    int  start = cyc;
    int  n = 0;
    bit  done = 1'b0;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    off = -1;
    while (!done) begin
      @(negedge clk);
      if (gnt[d] === 1'b1) begin
        exp_q[d].push_back('{data: want, due: cyc + lat_of(d)});
        off = cyc + 1 - start;
        done = 1'b1;
      end else if (++n > 40) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout dut%0d: got no gnt expected gnt within 40 cycles", d);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd, output int off);
    issue(d, 1'b1, a, b, wd, 32'h0, off);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] want, output int off);
    issue(d, 1'b0, a, 4'h0, 32'h0, want, off);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int off;
    int exp_off [6] = '{1, 1, 2, 1, 2, 1};

    for (int d = 0; d < N; d++) begin
      req[d] = 1'b1; we[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
    end

    // Reset with requests pending: no grant, responses idle.
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < N; d++) check($sformatf("gnt_in_reset_dut%0d", d), 32'(gnt[d]), 32'h0);
    end
    for (int d = 0; d < N; d++) req[d] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("rvalid_after_reset_dut%0d", d), 32'(rvalid[d]), 32'h0);
      check($sformatf("rdata_after_reset_dut%0d", d), rdata[d], 32'h0);
    end
    @(posedge clk); #1;

    // Defaults: same-cycle grant, read-after-write back to back.
    wr(0, 32'h10, 4'hF, 32'hDEADBEEF, off);
    check("t2_wr_gnt_offset", 32'(off), 32'd1);
    rd(0, 32'h10, 32'hDEADBEEF, off);
    check("t2_rd_gnt_offset", 32'(off), 32'd1);
    req[0] = 1'b0;
    drain();

    // Byte lanes.
    wr(0, 32'h20, 4'hF, 32'hFFFFFFFF, off);
    wr(0, 32'h20, 4'h5, 32'h11223344, off);
    rd(0, 32'h20, 32'hFF22FF44, off);
    req[0] = 1'b0;
    drain();

    // Address wrap and ignored byte offset.
    wr(0, 32'h0,   4'hF, 32'hCAFEF00D, off);
    wr(0, 32'h3FC, 4'hF, 32'h0BADF00D, off);
    rd(0, 32'h400, 32'hCAFEF00D, off);
    rd(0, 32'h403, 32'hCAFEF00D, off);
    rd(0, 32'h7FC, 32'h0BADF00D, off);
    req[0] = 1'b0;
    drain();

    // Wait states: grant in the 3rd request cycle, response 3 cycles after accept.
    wr(1, 32'h8, 4'hF, 32'h12345678, off);
    check("t4_wr_gnt_offset", 32'(off), 32'd3);
    rd(1, 32'h8, 32'h12345678, off);
    check("t4_rd_gnt_offset", 32'(off), 32'd3);
    req[1] = 1'b0;
    @(posedge clk); #1;
    // Abandoned request must not leave credit in the wait counter.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h8;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rd(1, 32'h8, 32'h12345678, off);
    check("t4_abort_gnt_offset", 32'(off), 32'd3);
    req[1] = 1'b0;
    drain();

    // Outstanding cap: six held reads stall at two in flight.
    for (int i = 0; i < 6; i++) wr(2, 32'(4 * i), 4'hF, 32'h50000000 + 32'(i), off);
    req[2] = 1'b0;
    drain();
    max_ocnt = 0;
    track_ocnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd(2, 32'(4 * i), 32'h50000000 + 32'(i), off);
      check($sformatf("t5_gnt_offset_%0d", i), 32'(off), 32'(exp_off[i]));
    end
    req[2] = 1'b0;
    drain();
    track_ocnt = 1'b0;
    check("t5_max_ocnt", 32'(max_ocnt), 32'd2);

    // Mid-operation reset drops two in-flight reads.
    rd(2, 32'h0, 32'h50000000, off);
    rd(2, 32'h4, 32'h50000001, off);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_gnt_in_reset", 32'(gnt[2]), 32'h0);
    @(posedge clk); #1;
    exp_q[2].delete();
    req[2] = 1'b0;
    check("t6_ocnt_reset", 32'(dut_c.ocnt_q), 32'h0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t6_ocnt_after", 32'(dut_c.ocnt_q), 32'h0);
    rd(2, 32'h14, 32'h50000005, off);
    check("t6_post_reset_gnt_offset", 32'(off), 32'd1);
    req[2] = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
